// File: rtl/key_schedule_ctrl.sv
// rtl/key_schedule_ctrl.sv - AES-128 round-key schedule controller driving an external single-round expander
// Optional expander watchdog and ERR state: define KEYSCHED_TIMEOUT_EN.
module key_schedule_ctrl #(
  parameter int NROUNDS   = 10,
  parameter int TO_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         keys_valid,
  output logic [127:0] exp_key_in,
  output logic [3:0]   exp_rnum,
  output logic         exp_en,
  output logic         exp_clr,
  input  logic [127:0] exp_key_out,
  input  logic         exp_done,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data
`ifdef KEYSCHED_TIMEOUT_EN
  ,
  output logic         err
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    WAIT,
    DONE
`ifdef KEYSCHED_TIMEOUT_EN
    ,
    ERR
`endif
  } state_t;

  state_t       state, state_nxt;
  logic [3:0]   round, round_nxt;
  logic         load_key, store_rk;
  logic         clr_hold;
  logic [127:0] slot [0:NROUNDS];

`ifdef KEYSCHED_TIMEOUT_EN
  localparam int TOW = $clog2(TO_CYCLES + 1);
  logic [TOW-1:0] to_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      round    <= 4'd1;
      clr_hold <= 1'b1;
    end else begin
      state    <= state_nxt;
      round    <= round_nxt;
      clr_hold <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    round_nxt = round;
    load_key  = 1'b0;
    store_rk  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load_key  = 1'b1;
          round_nxt = 4'd1;
          state_nxt = CLR;
        end
      end
`ifdef KEYSCHED_TIMEOUT_EN
      ERR: begin
        if (start) begin
          load_key  = 1'b1;
          round_nxt = 4'd1;
          state_nxt = CLR;
        end
      end
`endif
      CLR: state_nxt = WAIT;
      WAIT: begin
        if (exp_done) begin
          store_rk = 1'b1;
          if (round == 4'(NROUNDS)) begin
            state_nxt = DONE;
          end else begin
            round_nxt = round + 4'd1;
            state_nxt = CLR;
          end
        end
`ifdef KEYSCHED_TIMEOUT_EN
        else if (to_cnt == TOW'(TO_CYCLES - 1)) begin
          state_nxt = ERR;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Table is not reset: contents are only exposed through rk_data once DONE is reached.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (load_key) slot[0] <= key_in;
      if (store_rk) slot[round] <= exp_key_out;
    end
  end

`ifdef KEYSCHED_TIMEOUT_EN
  // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (reset || state != WAIT) begin
      to_cnt <= '0;
    end else if (!exp_done) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign err = (state == ERR);
`endif

  assign busy       = (state == CLR) || (state == WAIT);
  assign keys_valid = (state == DONE);
  assign exp_en     = (state == WAIT);
  assign exp_clr    = (state == CLR) || clr_hold;
  assign exp_rnum   = round;
  assign exp_key_in = busy ? slot[round - 4'd1] : 128'h0;
  assign rk_data    = (keys_valid && rk_addr <= 4'(NROUNDS)) ? slot[rk_addr] : 128'h0;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb/tb_key_schedule_ctrl.sv - self-checking bench for key_schedule_ctrl with an AES-128 expander model
module tb_key_schedule_ctrl;
  localparam int NR = 10;
  localparam int TO = 16;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam int P_IDLE = 0, P_CLR = 1, P_WAIT = 2, P_DONE = 3, P_ERR = 4;

  logic         clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, keys_valid, exp_en, exp_clr, exp_done;
  logic [127:0] exp_key_in, exp_key_out, rk_data;
  logic [3:0]   exp_rnum, rk_addr = '0;
`ifdef KEYSCHED_TIMEOUT_EN
  logic         err;
`endif

  key_schedule_ctrl #(.NROUNDS(NR), .TO_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in),
    .busy(busy), .keys_valid(keys_valid), .exp_key_in(exp_key_in),
    .exp_rnum(exp_rnum), .exp_en(exp_en), .exp_clr(exp_clr),
    .exp_key_out(exp_key_out), .exp_done(exp_done),
    .rk_addr(rk_addr), .rk_data(rk_data)
`ifdef KEYSCHED_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // AES-128 key expansion arithmetic
  logic [7:0] sbox_t [0:255];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] b);
    logic [7:0] inv;
    logic [15:0] d;
    inv = 8'h00;
    for (int x = 1; x < 256; x++)
      if (b != 8'h00 && gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
    d = {inv, inv};
    return inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input int r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 1; i < r; i++) c = {c[6:0], 1'b0} ^ (c[7] ? 8'h1b : 8'h00);
    return c;
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    {w0, w1, w2, w3} = k;
    t  = {sbox_t[w3[23:16]], sbox_t[w3[15:8]], sbox_t[w3[7:0]], sbox_t[w3[31:24]]} ^ {rcon(r), 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] rk_of(input logic [127:0] key, input int i);
    logic [127:0] k;
    k = key;
    for (int j = 1; j <= i; j++) k = next_rk(k, j);
    return k;
  endfunction

  initial for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));

  // Expander: result valid after W enabled cycles, sticky until exp_clr
  int   W = 2;
  int   xcnt = 0;
  logic xforce = 1'b0, xstuck = 1'b0;
  always @(posedge clk) begin
    if (exp_clr) xcnt <= 0;
    else if (exp_en) xcnt <= xcnt + 1;
  end
  assign exp_done = xforce | (!xstuck && !exp_clr && (xcnt >= W - 1));
  always @(exp_key_in or exp_rnum) exp_key_out = next_rk(exp_key_in, int'(exp_rnum));

  // Timeline model: after an accepted start, each round is one clear cycle plus W wait cycles
  int           cyc = 0, m_s = 0, m_mode = 0, m_w = 2;
  logic         m_stuck = 1'b0, m_hold = 1'b0;
  logic [127:0] m_rk [0:NR];

  function automatic int m_phase();
    int d;
    d = cyc - m_s;
    if (m_mode == 0) return P_IDLE;
    if (m_stuck) begin
      if (d == 0) return P_CLR;
`ifdef KEYSCHED_TIMEOUT_EN
      if (d > TO) return P_ERR;
`endif
      return P_WAIT;
    end
    if (d >= NR * (1 + m_w)) return P_DONE;
    return ((d % (1 + m_w)) == 0) ? P_CLR : P_WAIT;
  endfunction

  function automatic int m_round();
    if (m_stuck) return 1;
    return (cyc - m_s) / (1 + m_w) + 1;
  endfunction

  function automatic logic [127:0] m_rkdata(input logic [3:0] a);
    if (m_phase() != P_DONE || a > 4'(NR)) return 128'h0;
    return m_rk[a];
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_hold <= reset;
    if (reset) begin
      m_mode <= 0;
    end else if (start && (m_phase() == P_IDLE || m_phase() == P_DONE || m_phase() == P_ERR)) begin
      m_mode  <= 1;
      m_s     <= cyc + 1;
      m_w     <= W;
      m_stuck <= xstuck;
      for (int i = 0; i <= NR; i++) m_rk[i] <= rk_of(key_in, i);
    end
  end

  logic       checking = 1'b0;
  logic [3:0] clr_seq [$];

  always @(negedge clk) begin
    if (checking) begin
      chk("busy", busy, m_phase() == P_CLR || m_phase() == P_WAIT);
      chk("keys_valid", keys_valid, m_phase() == P_DONE);
      chk("exp_en", exp_en, m_phase() == P_WAIT);
      chk("exp_clr", exp_clr, m_phase() == P_CLR || m_hold);
      chk("rk_data", rk_data, m_rkdata(rk_addr));
`ifdef KEYSCHED_TIMEOUT_EN
      chk("err", err, m_phase() == P_ERR);
`endif
      if (m_phase() == P_CLR || m_phase() == P_WAIT) begin
        chk("exp_rnum", exp_rnum, m_round());
        chk("exp_key_in", exp_key_in, m_rk[m_round() - 1]);
      end
      if (exp_clr && busy) clr_seq.push_back(exp_rnum);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [127:0] d);
    rk_addr = a;
    #1;
    d = rk_data;
  endtask

  task automatic wait_kv(input int t0, output int lat);
    int n;
    n = 0;
    while (!keys_valid && n < 300) begin
      step(1);
      n++;
    end
    chk("keys_valid_reached", keys_valid, 1'b1);
    lat = cyc - t0;
  endtask

  task automatic run_sched(input logic [127:0] k, input int w, output int lat);
    int t0;
    W = w;
    key_in = k;
    start = 1'b1;
    t0 = cyc;
    step(1);
    start = 1'b0;
    key_in = '0;
    wait_kv(t0, lat);
  endtask

  initial begin
    int lat, t0, n;
    logic [127:0] d;

    step(3);
    checking = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_keys_valid", keys_valid, 1'b0);
    chk("rst_exp_en", exp_en, 1'b0);
    chk("rst_exp_clr", exp_clr, 1'b1);
    chk("rst_rk_data", rk_data, 128'h0);
`ifdef KEYSCHED_TIMEOUT_EN
    chk("rst_err", err, 1'b0);
`endif
    reset = 1'b0;
    step(1);
    chk("idle_exp_clr", exp_clr, 1'b0);
    xforce = 1'b1;
    rk_addr = 4'd3;
    step(3);
    chk("idle_done_ignored", busy, 1'b0);
    xforce = 1'b0;

    clr_seq.delete();
    run_sched(K1, 2, lat);
    chk("latency_w2", lat, 31);
    chk("clr_pulses", clr_seq.size(), 10);
    for (int i = 0; i < clr_seq.size() && i < 10; i++)
      chk($sformatf("rnum_seq%0d", i), clr_seq[i], i + 1);
    rd(4'd0, d); chk("k1_rk0", d, K1);
    rd(4'd1, d); chk("k1_rk1", d, 128'ha0fafe1788542cb123a339392a6c7605);
    rd(4'd10, d); chk("k1_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    step(1);
    for (int a = 11; a < 16; a++) begin
      rd(4'(a), d);
      chk($sformatf("rk_oob%0d", a), d, 128'h0);
    end

    W = 2;
    key_in = K1;
    start = 1'b1;
    t0 = cyc;
    step(1);
    start = 1'b0;
    step(10);
    chk("mid_round", exp_rnum, 4'd4);
    key_in = K2;
    start = 1'b1;
    step(1);
    start = 1'b0;
    key_in = '0;
    wait_kv(t0, lat);
    chk("latency_ignored_start", lat, 31);
    rd(4'd1, d); chk("ign_rk1", d, 128'ha0fafe1788542cb123a339392a6c7605);
    rd(4'd10, d); chk("ign_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_sched(K2, 1, lat);
    chk("latency_w1", lat, 21);
    rd(4'd1, d); chk("k2_rk1", d, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    rd(4'd10, d); chk("k2_rk10", d, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    W = 2;
    key_in = K1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(16);
    chk("r6_rnum", exp_rnum, 4'd6);
    chk("r6_wait", exp_en, 1'b1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    rk_addr = 4'd1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_keys_valid", keys_valid, 1'b0);
    chk("midrst_exp_clr", exp_clr, 1'b1);
    chk("midrst_rk_data", rk_data, 128'h0);
    step(1);
    run_sched(K2, 4, lat);
    chk("latency_w4", lat, 51);
    rd(4'd10, d); chk("post_rst_rk10", d, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    xstuck = 1'b1;
    key_in = K1;
    start = 1'b1;
    t0 = cyc;
    step(1);
    start = 1'b0;
`ifdef KEYSCHED_TIMEOUT_EN
    n = 0;
    while (!err && n < 100) begin
      step(1);
      n++;
    end
    chk("err_latency", cyc - t0, 2 + TO);
    chk("err_busy", busy, 1'b0);
    step(5);
    chk("err_sticky", err, 1'b1);
    xstuck = 1'b0;
    W = 2;
    key_in = K1;
    start = 1'b1;
    t0 = cyc;
    step(1);
    start = 1'b0;
    chk("err_cleared", err, 1'b0);
    chk("err_restart_busy", busy, 1'b1);
    wait_kv(t0, lat);
    rd(4'd10, d); chk("err_restart_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`else
    step(40);
    chk("stuck_busy", busy, 1'b1);
    chk("stuck_keys_valid", keys_valid, 1'b0);
    xstuck = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("stuck_reset_busy", busy, 1'b0);
`endif
    step(2);
    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/key_schedule_ctrl.md
KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 Parameter: NROUNDS, 10, number of round keys generated after the cipher key (AES-128).
REQ-002 Parameter: TO_CYCLES, 16, expander response timeout in cycles (used only with KEYSCHED_TIMEOUT_EN).
REQ-003 Port: clk  in  1  clock; all state changes on the rising edge.
REQ-004 Port: reset  in  1  reset, synchronous, active-high.
REQ-005 Port: start  in  1  request a full key schedule from key_in.
REQ-006 Port: key_in  in  128  cipher key, sampled only on an accepted start.
REQ-007 Port: busy  out  1  schedule in progress.
REQ-008 Port: keys_valid  out  1  all NROUNDS+1 round keys are stored and readable.
REQ-009 Port: exp_key_in  out  128  previous round key, driven to the single-round expander.
REQ-010 Port: exp_rnum  out  4  current round number, 1..NROUNDS, driven to the expander's round-constant select.
REQ-011 Port: exp_en  out  1  expander enable.
REQ-012 Port: exp_clr  out  1  expander reset; clears the expander's sticky done.
REQ-013 Port: exp_key_out  in  128  expander result.
REQ-014 Port: exp_done  in  1  expander result valid; sticky until exp_clr.
REQ-015 Port: rk_addr  in  4  round-key read index, 0..NROUNDS.
REQ-016 Port: rk_data  out  128  round key at rk_addr; combinational read.
REQ-017 Port: err  out  1  expander timeout flag; present only with KEYSCHED_TIMEOUT_EN.

Function
REQ-018 The FSM SHALL have the states IDLE, CLR, WAIT, DONE and ERR.
REQ-019 In IDLE or DONE, start=1 SHALL write key_in to slot 0, set round=1, clear keys_valid and go to CLR; start in CLR or WAIT SHALL be ignored.
REQ-020 CLR SHALL last exactly one cycle with exp_clr=1 and exp_en=0, then go to WAIT.
REQ-021 In CLR and WAIT, exp_key_in SHALL equal slot[round-1] and exp_rnum SHALL equal round.
REQ-022 In WAIT, exp_en SHALL be 1 continuously; exp_done is sampled only in WAIT.
REQ-023 When WAIT samples exp_done=1, the FSM SHALL write exp_key_out to slot[round]; if round==NROUNDS it SHALL go to DONE, otherwise it SHALL increment round and go to CLR.
REQ-024 busy SHALL be 1 in CLR and WAIT only, and keys_valid SHALL be 1 in DONE only.
REQ-025 A schedule SHALL take 1 + NROUNDS*(1+W) cycles from start sampled to keys_valid high, where W is the number of WAIT cycles per round.
REQ-026 rk_data SHALL be slot[rk_addr] when keys_valid=1 and rk_addr<=NROUNDS, and 128'h0 otherwise.
REQ-027 exp_done=1 sampled outside WAIT SHALL have no effect.
REQ-028 The key table SHALL be 11 x 128-bit registers; slots not yet written in a running schedule SHALL be unreadable, because keys_valid=0.

Reset
REQ-029 reset=1 SHALL force IDLE, round=1, busy=0, keys_valid=0, exp_en=0, exp_clr=1, err=0 and rk_data=0 from the next edge, including mid-schedule.
REQ-030 Key-table contents SHALL be don't-care after reset, and are never exposed while keys_valid=0.

Configuration
REQ-031 With KEYSCHED_TIMEOUT_EN defined: a counter cleared on entry to WAIT SHALL move the FSM to ERR if TO_CYCLES WAIT cycles pass without exp_done.
REQ-032 In ERR: err=1, busy=0, keys_valid=0 and exp_en=0; start SHALL clear err and restart as from IDLE; only start or reset exits ERR.
REQ-033 Without KEYSCHED_TIMEOUT_EN: the err port, the counter and the ERR state SHALL be absent, and WAIT SHALL wait indefinitely.

Verification
REQ-034 Model expander (FIPS-197) with key 2b7e151628aed2a6abf7158809cf4f3c -> rk_addr=1 reads a0fafe1788542cb123a339392a6c7605 and rk_addr=10 reads d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-035 Expander with W=2 -> keys_valid rises exactly 31 cycles after start, with exactly 10 exp_clr pulses and exp_rnum sequence 1..10.
REQ-036 start pulsed during round 4 -> ignored; final keys are identical to REQ-034.
REQ-037 reset asserted in WAIT of round 6 -> next cycle IDLE, busy=0, keys_valid=0; a new start then completes correctly.
REQ-038 rk_addr=11..15 with keys_valid=1, and any rk_addr with keys_valid=0 -> rk_data=0.
REQ-039 KEYSCHED_TIMEOUT_EN defined with exp_done stuck at 0 -> err=1 after 16 WAIT cycles of round 1; a following start clears err.
